// File: rtl/life_pkg.sv
// Shared state encoding, neighborhood ordering and coordinate helpers for the
// Game of Life window datapath; every neighbor-count checker relies on this order.
package life_pkg;

    typedef logic [0:0] state_t;
    localparam state_t LOAD = 1'b0;
    localparam state_t SCAN = 1'b1;

    // Neighborhood index order: Tl, T, Tr, L, C, R, Bl, B, Br (index 4 is the center).
    localparam int NB_N = 9;
    localparam int NB_DX [NB_N] = '{-1, 0, 1, -1, 0, 1, -1, 0, 1};
    localparam int NB_DY [NB_N] = '{-1, -1, -1, 0, 0, 0, 1, 1, 1};

    function automatic int coord_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/life_frame_buf.sv
// WIDTH x HEIGHT single-bit cell store with one write port and a combinational
// 3x3 neighborhood read; out-of-grid taps read 0 or wrap toroidally per WRAP.
module life_frame_buf
    import life_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int HEIGHT = 16,
    parameter bit WRAP   = 1'b0,
    parameter int XW     = coord_w(WIDTH),
    parameter int YW     = coord_w(HEIGHT)
) (
    input  logic            clk,
    input  logic            wr_en,
    input  logic [XW-1:0]   wr_x,
    input  logic [YW-1:0]   wr_y,
    input  logic            wr_dat,
    input  logic [XW-1:0]   rd_x,
    input  logic [YW-1:0]   rd_y,
    output logic [NB_N-1:0] nb_dat
);

    logic [WIDTH-1:0] mem_q [HEIGHT];
    logic [WIDTH-1:0] mem_d [HEIGHT];
    int               nx;
    int               ny;
    logic             in_grid;

    always_comb begin
        mem_d = mem_q;
        if (wr_en) begin
            mem_d[wr_y][wr_x] = wr_dat;
        end
    end

    // Contents are deliberately not reset: a frame is always fully loaded before a scan.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_comb begin
        nb_dat  = '0;
        nx      = 0;
        ny      = 0;
        in_grid = 1'b0;
        for (int k = 0; k < NB_N; k++) begin
            nx      = int'(rd_x) + NB_DX[k];
            ny      = int'(rd_y) + NB_DY[k];
            in_grid = (nx >= 0) && (nx < WIDTH) && (ny >= 0) && (ny < HEIGHT);
            if (WRAP) begin
                if (nx < 0)            nx = nx + WIDTH;
                else if (nx >= WIDTH)  nx = nx - WIDTH;
                if (ny < 0)            ny = ny + HEIGHT;
                else if (ny >= HEIGHT) ny = ny - HEIGHT;
                in_grid = 1'b1;
            end
            if (in_grid) begin
                nb_dat[k] = mem_q[ny[YW-1:0]][nx[XW-1:0]];
            end
        end
    end

endmodule

// File: rtl/life_window_gen.sv
// Loads one raster frame (LOAD), then streams one 3x3 window per cell (SCAN).
// Window outputs decode combinationally from registered scan counters; win_ready only gates advance.
module life_window_gen
    import life_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int HEIGHT = 16,
    parameter bit WRAP   = 1'b0,
    parameter int XW     = coord_w(WIDTH),
    parameter int YW     = coord_w(HEIGHT)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cell_in,
    input  logic          cell_sof,
    input  logic          cell_valid,
    output logic          cell_ready,
    output logic          Tl,
    output logic          T,
    output logic          Tr,
    output logic          L,
    output logic          R,
    output logic          Bl,
    output logic          B,
    output logic          Br,
    output logic          C,
    output logic [XW-1:0] win_x,
    output logic [YW-1:0] win_y,
    output logic          win_last,
    output logic          win_valid,
    input  logic          win_ready
);

    localparam logic [XW-1:0] X_MAX = XW'(WIDTH - 1);
    localparam logic [YW-1:0] Y_MAX = YW'(HEIGHT - 1);

    state_t          state_q, state_d;
    logic [XW-1:0]   lx_q, lx_d, sx_q, sx_d;
    logic [YW-1:0]   ly_q, ly_d, sy_q, sy_d;
    logic [XW-1:0]   wr_x;
    logic [YW-1:0]   wr_y;
    logic            scan_act, load_hs, scan_hs, at_last;
    logic [NB_N-1:0] nb_dat;

    assign scan_act   = rst_n && (state_q == SCAN);
    assign cell_ready = rst_n && (state_q == LOAD);
    assign win_valid  = scan_act;
    assign load_hs    = cell_valid && cell_ready;
    assign scan_hs    = win_valid && win_ready;
    assign at_last    = (sx_q == X_MAX) && (sy_q == Y_MAX);
    // A start-of-frame cell always lands at the origin, resynchronising mid-frame.
    assign wr_x       = cell_sof ? '0 : lx_q;
    assign wr_y       = cell_sof ? '0 : ly_q;

    always_comb begin
        state_d = state_q;
        lx_d    = lx_q;
        ly_d    = ly_q;
        sx_d    = sx_q;
        sy_d    = sy_q;
        if (load_hs) begin
            if (cell_sof) begin
                lx_d = XW'(1);
                ly_d = '0;
            end else if (lx_q == X_MAX) begin
                lx_d = '0;
                if (ly_q == Y_MAX) begin
                    ly_d    = '0;
                    state_d = SCAN;
                end else begin
                    ly_d = ly_q + YW'(1);
                end
            end else begin
                lx_d = lx_q + XW'(1);
            end
        end
        if (scan_hs) begin
            if (at_last) begin
                sx_d    = '0;
                sy_d    = '0;
                state_d = LOAD;
            end else if (sx_q == X_MAX) begin
                sx_d = '0;
                sy_d = sy_q + YW'(1);
            end else begin
                sx_d = sx_q + XW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= LOAD;
            lx_q    <= '0;
            ly_q    <= '0;
            sx_q    <= '0;
            sy_q    <= '0;
        end else begin
            state_q <= state_d;
            lx_q    <= lx_d;
            ly_q    <= ly_d;
            sx_q    <= sx_d;
            sy_q    <= sy_d;
        end
    end

    life_frame_buf #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT),
        .WRAP   (WRAP),
        .XW     (XW),
        .YW     (YW)
    ) u_buf (
        .clk    (clk),
        .wr_en  (load_hs),
        .wr_x   (wr_x),
        .wr_y   (wr_y),
        .wr_dat (cell_in),
        .rd_x   (sx_q),
        .rd_y   (sy_q),
        .nb_dat (nb_dat)
    );

    assign Tl       = scan_act & nb_dat[0];
    assign T        = scan_act & nb_dat[1];
    assign Tr       = scan_act & nb_dat[2];
    assign L        = scan_act & nb_dat[3];
    assign C        = scan_act & nb_dat[4];
    assign R        = scan_act & nb_dat[5];
    assign Bl       = scan_act & nb_dat[6];
    assign B        = scan_act & nb_dat[7];
    assign Br       = scan_act & nb_dat[8];
    assign win_x    = scan_act ? sx_q : '0;
    assign win_y    = scan_act ? sy_q : '0;
    assign win_last = scan_act & at_last;

endmodule

// File: tb/tb_life_window_gen.sv
// Bench for life_window_gen: four configurations (4x4 and 16x16, both WRAP values)
// checked every cycle against a position-based reference model of the grid.
module tb_life_window_gen;

    localparam int NCFG = 4;
    localparam int CFG_W    [NCFG] = '{4, 4, 16, 16};
    localparam int CFG_H    [NCFG] = '{4, 4, 16, 16};
    localparam bit CFG_WRAP [NCFG] = '{1'b0, 1'b1, 1'b0, 1'b1};

    logic clk = 1'b0;
    logic rst_n, cell_in, cell_sof, cell_valid, win_ready;
    int   sel;

    always #5 clk = ~clk;

    logic       cr_o [NCFG];
    logic       wv_o [NCFG];
    logic       wl_o [NCFG];
    logic [8:0] nb_o [NCFG];
    logic [3:0] wx_o [NCFG];
    logic [3:0] wy_o [NCFG];

    for (genvar g = 0; g < NCFG; g++) begin : g_dut
        localparam int W  = CFG_W[g];
        localparam int H  = CFG_H[g];
        localparam bit WR = CFG_WRAP[g];
        logic [$clog2(W)-1:0] x_w;
        logic [$clog2(H)-1:0] y_w;
        logic tl, t, tr, l, c, r, bl, b, br, cr, wv, wl;

        life_window_gen #(.WIDTH(W), .HEIGHT(H), .WRAP(WR)) u_dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .cell_in    (cell_in),
            .cell_sof   (cell_sof),
            .cell_valid (cell_valid && (sel == g)),
            .cell_ready (cr),
            .Tl         (tl),
            .T          (t),
            .Tr         (tr),
            .L          (l),
            .R          (r),
            .Bl         (bl),
            .B          (b),
            .Br         (br),
            .C          (c),
            .win_x      (x_w),
            .win_y      (y_w),
            .win_last   (wl),
            .win_valid  (wv),
            .win_ready  (win_ready)
        );

        assign cr_o[g] = cr;
        assign wv_o[g] = wv;
        assign wl_o[g] = wl;
        assign nb_o[g] = {br, b, bl, r, c, l, tr, t, tl};
        assign wx_o[g] = 4'(x_w);
        assign wy_o[g] = 4'(y_w);
    end

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: grid contents plus linear load / scan positions.
    bit grid [16][16];
    bit m_scan = 1'b0;
    int m_p = 0;
    int m_s = 0;

    function automatic logic [8:0] exp_win(input int x, input int y, input int w, input int h, input bit wrap);
        logic [8:0] res;
        int k;
        res = '0;
        k   = 0;
        for (int dy = -1; dy <= 1; dy++) begin
            for (int dx = -1; dx <= 1; dx++) begin
                int nx, ny;
                nx = x + dx;
                ny = y + dy;
                if (wrap) begin
                    nx = (nx + w) % w;
                    ny = (ny + h) % h;
                end
                if (nx >= 0 && nx < w && ny >= 0 && ny < h) res[k] = grid[ny][nx];
                k++;
            end
        end
        return res;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            m_scan <= 1'b0;
            m_p    <= 0;
            m_s    <= 0;
        end else if (!m_scan) begin
            if (cell_valid) begin
                if (cell_sof) begin
                    grid[0][0] <= cell_in;
                    m_p        <= 1;
                end else begin
                    grid[m_p / CFG_W[sel]][m_p % CFG_W[sel]] <= cell_in;
                    if (m_p == CFG_W[sel] * CFG_H[sel] - 1) begin
                        m_scan <= 1'b1;
                        m_p    <= 0;
                        m_s    <= 0;
                    end else begin
                        m_p <= m_p + 1;
                    end
                end
            end
        end else if (win_ready) begin
            if (m_s == CFG_W[sel] * CFG_H[sel] - 1) begin
                m_scan <= 1'b0;
                m_s    <= 0;
            end else begin
                m_s <= m_s + 1;
            end
        end
    end

    logic [8:0] cap_nb   [256];
    logic       cap_last [256];
    int         seq [$];
    int         frames_done = 0;

    always @(negedge clk) begin
        int w, h, idx;
        w = CFG_W[sel];
        h = CFG_H[sel];
        if (!rst_n) begin
            check("rst_cell_ready", 32'(cr_o[sel]), 0);
            check("rst_win_valid", 32'(wv_o[sel]), 0);
        end else begin
            check("cell_ready", 32'(cr_o[sel]), 32'(!m_scan));
            check("win_valid", 32'(wv_o[sel]), 32'(m_scan));
            if (m_scan) begin
                check("win_x", 32'(wx_o[sel]), m_s % w);
                check("win_y", 32'(wy_o[sel]), m_s / w);
                check("win_last", 32'(wl_o[sel]), 32'(m_s == w * h - 1));
                check("window", 32'(nb_o[sel]), 32'(exp_win(m_s % w, m_s / w, w, h, CFG_WRAP[sel])));
                if (wv_o[sel] && win_ready) begin
                    idx = int'(wy_o[sel]) * w + int'(wx_o[sel]);
                    cap_nb[idx]   = nb_o[sel];
                    cap_last[idx] = wl_o[sel];
                    seq.push_back(idx);
                    if (wl_o[sel]) frames_done++;
                end
            end else begin
                check("idle_outputs", {14'd0, wx_o[sel], wy_o[sel], wl_o[sel], nb_o[sel]}, 0);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int s);
        rst_n      = 1'b0;
        cell_valid = 1'b0;
        cell_sof   = 1'b0;
        win_ready  = 1'b0;
        sel        = s;
        cyc();
        cyc();
        rst_n = 1'b1;
        seq.delete();
        frames_done = 0;
    endtask

    task automatic send_cell(input bit v, input bit sof);
        cell_in    = v;
        cell_sof   = sof;
        cell_valid = 1'b1;
        cyc();
        cell_valid = 1'b0;
        cell_sof   = 1'b0;
    endtask

    task automatic load_frame(input logic [255:0] bits, input int n);
        for (int i = 0; i < n; i++) send_cell(bits[i], i == 0);
    endtask

    task automatic wait_last(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            seen = wl_o[sel] && wv_o[sel] && win_ready;
        end
        check({name, "_last_seen"}, 32'(seen), 1);
        @(negedge clk);
    endtask

    task automatic check_seq(input string name, input int n);
        check({name, "_seq_len"}, seq.size(), n);
        for (int i = 0; i < n && i < seq.size(); i++) check({name, "_seq"}, seq[i], i);
    endtask

    initial begin
        bit       found;
        bit [3:0] pat;
        rst_n      = 1'b0;
        cell_in    = 1'b0;
        cell_sof   = 1'b0;
        cell_valid = 1'b0;
        win_ready  = 1'b0;
        sel        = 0;

        // Glider, 4x4, no wrap.
        do_reset(0);
        win_ready = 1'b1;
        load_frame(256'h742, 16);
        wait_last("glider");
        check("glider_cell_ready_back", 32'(cr_o[0]), 1);
        check("glider_win_valid_low", 32'(wv_o[0]), 0);
        check("glider_w11", 32'(cap_nb[5]), 32'(9'b111100010));
        check("glider_w00", 32'(cap_nb[0]), 32'(9'b000100000));
        check("glider_last33", 32'(cap_last[15]), 1);
        check("glider_last32", 32'(cap_last[14]), 0);
        check_seq("glider", 16);

        // Toroidal wrap with only (3,3) alive.
        do_reset(1);
        win_ready = 1'b1;
        load_frame(256'h8000, 16);
        wait_last("wrap");
        check("wrap_w00", 32'(cap_nb[0]), 32'(9'b000000001));
        check("wrap_w33", 32'(cap_nb[15]), 32'(9'b000010000));

        // Backpressure pattern 1,0,0,1.
        do_reset(0);
        load_frame(256'($urandom), 16);
        pat = 4'b1001;
        for (int k = 0; k < 40; k++) begin
            win_ready = pat[k[1:0]];
            cyc();
        end
        win_ready = 1'b0;
        check_seq("bp", 16);

        // Mid-frame resync.
        do_reset(0);
        for (int i = 0; i < 5; i++) send_cell(1'($urandom), i == 0);
        send_cell(1'b1, 1'b1);
        for (int i = 0; i < 14; i++) send_cell(1'($urandom), 1'b0);
        check("resync_not_yet", 32'(wv_o[0]), 0);
        check("resync_still_load", 32'(cr_o[0]), 1);
        send_cell(1'($urandom), 1'b0);
        check("resync_scan", 32'(wv_o[0]), 1);
        win_ready = 1'b1;
        wait_last("resync");

        // Reset in the middle of the scan at window (2,1).
        do_reset(0);
        win_ready = 1'b1;
        load_frame(256'($urandom), 16);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            found = wv_o[0] && (wx_o[0] == 4'd2) && (wy_o[0] == 4'd1);
        end
        check("rst_hit_21", 32'(found), 1);
        #2;
        rst_n     = 1'b0;
        win_ready = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_win_valid", 32'(wv_o[0]), 0);
        check("post_rst_cell_ready", 32'(cr_o[0]), 1);
        seq.delete();
        win_ready = 1'b1;
        load_frame(256'($urandom), 16);
        wait_last("after_rst");
        check_seq("after_rst", 16);

        // Random 16x16 traffic for both wrap modes.
        for (int s = 2; s < 4; s++) begin
            do_reset(s);
            for (int i = 0; i < 4000; i++) begin
                cell_in    = 1'($urandom);
                cell_valid = ($urandom % 10) < 7;
                cell_sof   = (i == 0) || ($urandom % 2000 == 0);
                win_ready  = ($urandom % 10) < 6;
                cyc();
            end
            cell_valid = 1'b0;
            cell_sof   = 1'b0;
            check("rand_frames_done", 32'(frames_done >= 2), 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/life_window_gen.md
# life_window_gen

Frame buffer and neighborhood streamer for the Game of Life datapath. It accepts one raster-ordered frame of single-bit cells, then emits one 3x3 neighborhood per cell over a valid/ready handshake. The eight neighbor outputs (Tl, T, Tr, L, R, Bl, B, Br) connect directly to the neighbor-count checkers, and the center bit C goes to the next-state logic. It produces the neighbor bits that the checkers consume.

## Interface
Parameters:
- WIDTH, 16: grid columns, minimum 3.
- HEIGHT, 16: grid rows, minimum 3.
- WRAP, 0: 0 means out-of-grid neighbors read as dead (0); 1 means toroidal wrap-around.
- XW / YW, $clog2(WIDTH) / $clog2(HEIGHT): coordinate widths (derived).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- cell_in  in  1  cell state, 1 = alive.
- cell_sof  in  1  marks the first cell of a frame; sampled only on a handshake.
- cell_valid  in  1  upstream valid.
- cell_ready  out  1  high only in LOAD.
- Tl, T, Tr, L, R, Bl, B, Br  out  1 each  neighbors of the current scan cell.
- C  out  1  current scan cell.
- win_x  out  XW  scan column.
- win_y  out  YW  scan row.
- win_last  out  1  high for window (WIDTH-1, HEIGHT-1).
- win_valid  out  1  high only in SCAN.
- win_ready  in  1  downstream ready.

## Operation
- Two states: LOAD and SCAN.
- Reset (clk edge with rst_n=0): state = LOAD, load counters lx/ly = 0, scan counters sx/sy = 0. Buffer contents are not reset.
- Reset outputs: cell_ready=0 while rst_n=0. win_valid=0. All window bits, win_x, win_y and win_last are 0.
- LOAD:
  - cell_ready=1.
  - A handshake (cell_valid & cell_ready) writes buf[ly][lx] = cell_in, then advances lx.
  - lx wraps to 0 at WIDTH-1 and ly increments.
  - cell_sof=1 on a handshake forces that cell to (0,0), and the counters continue from (1,0). This gives mid-frame resync.
  - A handshake at (WIDTH-1, HEIGHT-1) transitions to SCAN and clears lx/ly.
- SCAN:
  - cell_ready=0. The buffer is frozen.
  - win_valid=1, and the window outputs decode combinationally from buf at (sx,sy).
  - Neighbor (dx,dy) is read at (sx+dx, sy+dy), with T/B at dy=-1/+1 and L/R at dx=-1/+1.
  - Out-of-range neighbors: 0 when WRAP=0. When WRAP=1, indices wrap modulo WIDTH/HEIGHT (for example, -1 maps to WIDTH-1).
  - A handshake (win_valid & win_ready) advances sx, wrapping into sy.
  - A handshake with win_last=1 returns to LOAD and clears sx/sy.
- Outputs are held stable while win_valid=1 and win_ready=0.
- Outside SCAN, all window outputs are 0.

## Timing
- The last load handshake at edge N puts the block in SCAN: win_valid=1 and window (0,0) are valid after edge N; cell_ready=0 after edge N.
- The last scan handshake at edge M puts the block in LOAD: cell_ready=1 and win_valid=0 after edge M.
- Throughput is one cell per cycle in LOAD and one window per cycle in SCAN with win_ready held at 1. A full frame takes 2·WIDTH·HEIGHT cycles.
- There is no combinational path from win_ready to win_valid, or from cell_valid to cell_ready.
- rst_n low mid-LOAD or mid-SCAN: after the edge the block is in LOAD at (0,0), and any partial frame is discarded.
- cell_sof is ignored in SCAN, because no handshake is possible there.

## Structure
- Shared package life_pkg holds:
  - typedef state_t with values LOAD and SCAN;
  - the neighbor offset constants;
  - coordinate width functions.
- The same neighbor ordering (Tl..Br) is used by every neighbor-count checker.
- Sub-module life_frame_buf contains the WIDTH×HEIGHT register array, the write port and the 9-output neighborhood mux, including the WRAP handling.
- The top level owns the FSM, the counters and the handshakes.

## Test plan
- WIDTH=HEIGHT=4, WRAP=0, a glider loaded with win_ready=1 throughout:
  - window (1,1) matches the glider's neighbor bits;
  - window (0,0) has Tl=T=Tr=L=Bl=0;
  - win_last=1 at (3,3);
  - cell_ready returns 1 one cycle after the last window.
- WRAP=1 with only cell (3,3) alive: window (0,0) shows Tl=1 and all other bits 0; window (3,3) shows C=1.
- Backpressure: win_ready toggles 1,0,0,1 during SCAN. Window (x,y) holds stable across the stall, and no window is skipped or duplicated (checked by the sequence of win_x/win_y).
- Resync: after 5 loaded cells, a cell_sof=1 handshake restarts the frame. SCAN begins only after WIDTH·HEIGHT further cells, counted from the sof cell inclusive.
- Reset mid-SCAN at window (2,1):
  - win_valid=0 and cell_ready=1 in the cycle after rst_n rises;
  - the next frame streams from (0,0).
- A random 16×16 frame with random valid/ready: every window matches a software reference model, for both WRAP values.
